// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM duty ramp generator: state and mode
// encodings and the default widths.
package pwm_ramp_pkg;

    localparam int unsigned BW_DEF    = 3;
    localparam int unsigned DIVBW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ramp_state_e;

    typedef enum logic {
        MODE_TRI = 1'b0,
        MODE_SAW = 1'b1
    } ramp_mode_e;

endpackage : pwm_ramp_pkg

// File: rtl/pwm_ramp_counter.sv
// Free-running up counter with synchronous clear, used as the ramp step
// prescaler.
module pwm_ramp_counter #(
    parameter int unsigned BW = 8
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          clr_i,
    output logic [BW-1:0] cnt_o
);

    logic [BW-1:0] cnt_q;

    // Count up every clock unless cleared.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + BW'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule : pwm_ramp_counter

// File: rtl/pwm_ramp.sv
// Duty-cycle ramp generator feeding a PWM stage: sweeps onCnt_o in a
// triangle or sawtooth between 0 and a shadowed period, one step per
// prescaled tick. Period and mode changes are only taken at ramp wrap.
module pwm_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned DIVBW = DIVBW_DEF
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             enable_i,
    input  logic             mode_i,
    input  logic [BW-1:0]    periodCnt_i,
    input  logic [DIVBW-1:0] stepDiv_i,
    output logic [BW-1:0]    onCnt_o,
    output logic [BW-1:0]    periodCnt_o,
    output logic             dir_o,
    output logic             wrap_o
);

    ramp_state_e      state_q;
    ramp_mode_e       mode_q;
    logic [BW-1:0]    on_q;
    logic [BW-1:0]    shadow_q;
    logic             dir_q;
    logic             wrap_q;

    logic [DIVBW-1:0] presc;
    logic             tick;
    logic             presc_clr;

    pwm_ramp_counter #(
        .BW (DIVBW)
    ) u_presc (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .clr_i  (presc_clr),
        .cnt_o  (presc)
    );

    // Step tick and prescaler clear; >= tolerates stepDiv_i lowered mid-count.
    always_comb begin
        tick      = 1'b0;
        presc_clr = 1'b0;
        if (state_q != ST_IDLE) begin
            tick = (presc >= stepDiv_i);
        end
        if ((state_q == ST_IDLE) || !enable_i || tick) begin
            presc_clr = 1'b1;
        end
    end

    // Ramp state machine with registered duty, direction and wrap outputs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_TRI;
            on_q     <= '0;
            shadow_q <= '0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    on_q     <= '0;
                    dir_q    <= 1'b0;
                    shadow_q <= periodCnt_i;
                    mode_q   <= ramp_mode_e'(mode_i);
                    if (enable_i) begin
                        state_q <= ST_UP;
                    end
                end
                ST_UP: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                        on_q    <= '0;
                        dir_q   <= 1'b0;
                    end else if (tick) begin
                        if (on_q < shadow_q) begin
                            on_q <= on_q + BW'(1);
                        end else if (mode_q == MODE_TRI) begin
                            state_q <= ST_DOWN;
                            dir_q   <= 1'b1;
                        end else begin
                            on_q     <= '0;
                            wrap_q   <= 1'b1;
                            shadow_q <= periodCnt_i;
                            mode_q   <= ramp_mode_e'(mode_i);
                        end
                    end
                end
                ST_DOWN: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                        on_q    <= '0;
                        dir_q   <= 1'b0;
                    end else if (tick) begin
                        if (on_q != '0) begin
                            on_q <= on_q - BW'(1);
                        end else begin
                            state_q  <= ST_UP;
                            dir_q    <= 1'b0;
                            wrap_q   <= 1'b1;
                            shadow_q <= periodCnt_i;
                            mode_q   <= ramp_mode_e'(mode_i);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    on_q    <= '0;
                    dir_q   <= 1'b0;
                end
            endcase
        end
    end

    assign onCnt_o     = on_q;
    assign periodCnt_o = shadow_q;
    assign dir_o       = dir_q;
    assign wrap_o      = wrap_q;

endmodule : pwm_ramp

// File: doc/pwm_ramp.md
PWM_RAMP -- requirements
Module: pwm_ramp

Interface
REQ-001 SHALL have parameter BW, default 3: width of the duty and period values; matches the pwm stage width.
REQ-002 SHALL have parameter DIVBW, default 8: width of the step prescaler.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port nrst_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port enable_i, input, 1: high = ramp runs; low = return to IDLE.
REQ-006 SHALL have port mode_i, input, 1: 0 = triangle ramp, 1 = sawtooth ramp.
REQ-007 SHALL have port periodCnt_i, input, BW: requested PWM period value.
REQ-008 SHALL have port stepDiv_i, input, DIVBW: clocks per ramp step, minus 1.
REQ-009 SHALL have port onCnt_o, output, BW: duty value driven into the pwm stage's onCnt_i.
REQ-010 SHALL have port periodCnt_o, output, BW: latched period driven into the pwm stage's periodCnt_i.
REQ-011 SHALL have port dir_o, output, 1: 1 while in state DOWN, else 0.
REQ-012 SHALL have port wrap_o, output, 1: one-cycle pulse at each ramp cycle boundary.

Function
REQ-013 SHALL implement states IDLE, UP and DOWN; all outputs are registered.
REQ-014 In IDLE: onCnt_o = 0, dir_o = 0, wrap_o = 0; shadow period and mode reload from periodCnt_i and mode_i every cycle.
REQ-015 IDLE with enable_i sampled high SHALL go to UP on that edge, clear the prescaler, and latch shadow period and mode.
REQ-016 enable_i sampled low in UP or DOWN SHALL go to IDLE on that edge: onCnt_o <= 0, prescaler cleared, no wrap_o.
REQ-017 In UP/DOWN, each cycle: if prescaler >= stepDiv_i, assert internal tick and clear the prescaler; else increment the prescaler. Using >= tolerates stepDiv_i being lowered mid-count.
REQ-018 stepDiv_i = 0 SHALL give one tick per clock; the first tick after entering UP falls on the (stepDiv_i+1)-th edge.
REQ-019 UP tick with onCnt_o < shadow SHALL increment onCnt_o.
REQ-020 UP tick with onCnt_o >= shadow:
- triangle: go to DOWN, onCnt_o unchanged (dwell at top).
- sawtooth: onCnt_o <= 0, pulse wrap_o, relatch shadow period and mode.
REQ-021 DOWN tick with onCnt_o > 0 SHALL decrement onCnt_o.
REQ-022 DOWN tick with onCnt_o = 0 SHALL go to UP with onCnt_o unchanged, pulse wrap_o, and relatch shadow period and mode.
REQ-023 Ramp length: triangle = 2*(shadow+1) ticks; sawtooth = shadow+1 ticks.
REQ-024 Shadow = 0 SHALL hold onCnt_o at 0 while still producing wrap_o at the correct period.
REQ-025 Changes on periodCnt_i or mode_i mid-ramp SHALL take effect only at the next wrap, so onCnt_o never exceeds periodCnt_o.
REQ-026 periodCnt_o SHALL always equal the shadow period; arithmetic is unsigned BW-bit with no overflow, since onCnt_o <= shadow <= 2^BW-1.

Reset
REQ-027 nrst_i low SHALL immediately force state IDLE and clear onCnt_o, periodCnt_o, dir_o, wrap_o, the prescaler, shadow period and mode, independent of clk_i.
REQ-028 A reset asserted mid-ramp SHALL abort the ramp with no wrap_o; after release, operation resumes from IDLE per REQ-015.

Structure
REQ-029 The state encoding (IDLE/UP/DOWN) and the BW/DIVBW defaults SHALL live in the shared project package.
REQ-030 The prescaler SHALL be the existing counter sub-module (BW = DIVBW), with its synchronous clear asserted on tick or in IDLE; all remaining logic stays inline.

Verification
REQ-031 Reset mid-ramp: assert nrst_i low while onCnt_o = 2 -> all outputs 0 without waiting for a clock edge; no wrap_o.
REQ-032 Triangle: periodCnt_i=3, stepDiv_i=0, mode_i=0, enable_i high -> onCnt_o per tick 0,1,2,3,3,2,1,0,0,1...; dir_o high during 3..0; wrap_o once per 8 ticks.
REQ-033 Sawtooth: periodCnt_i=5, stepDiv_i=0, mode_i=1 -> onCnt_o 0,1,2,3,4,5,0,1...; wrap_o on each 5->0 edge.
REQ-034 Prescale: stepDiv_i=3 -> onCnt_o changes exactly every 4 clocks; first increment on the 4th edge after entering UP.
REQ-035 Mid-ramp update: change periodCnt_i from 7 to 2 while onCnt_o = 4 -> periodCnt_o stays 7 until wrap, then 2; onCnt_o never exceeds periodCnt_o.
REQ-036 Disable: enable_i low while in DOWN at onCnt_o = 5 -> next edge IDLE, onCnt_o = 0, dir_o = 0, no wrap_o.
